// File: rtl/edge_detect_pkg.sv
// Shared definitions for the edge detector: edge-select encodings, legal
// parameter ranges and small helpers used by the channel logic.
package edge_detect_pkg;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } mode_t;

    localparam int WIDTH_MIN    = 1;
    localparam int WIDTH_MAX    = 32;
    localparam int SYNC_MIN     = 2;
    localparam int SYNC_MAX     = 4;
    localparam int DEBOUNCE_MIN = 1;
    localparam int DEBOUNCE_MAX = 65535;

    // A filter of one cycle still needs a one-bit counter to hold its zero.
    function automatic int cnt_width(input int debounce);
        int w;
        w = $clog2(debounce);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic edge_match(input mode_t mode, input logic new_level);
        logic hit;
        hit = 1'b0;
        case (mode)
            MODE_RISE: hit = new_level;
            MODE_FALL: hit = ~new_level;
            MODE_BOTH: hit = 1'b1;
            MODE_OFF:  hit = 1'b0;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_detect_if.sv
// Channel bus of the edge detector: raw inputs and controls towards the
// block, filtered levels and event flags back out.
interface edge_detect_if
    import edge_detect_pkg::*;
#(
    parameter int WIDTH = 4
) ();

    logic [WIDTH-1:0] in;
    mode_t            mode;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] pulse;
    logic [WIDTH-1:0] pending;
    logic             irq;

    modport master (
        output in, mode, clr,
        input  level, pulse, pending, irq
    );

    modport slave (
        input  in, mode, clr,
        output level, pulse, pending, irq
    );

endinterface

// File: rtl/edge_detect_chan.sv
// One edge-detector channel: synchroniser, debounce filter, accepted level,
// registered edge pulse and sticky pending flag.
module edge_detect_chan
    import edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in,
    input  mode_t mode,
    input  logic  clr,
    output logic  level,
    output logic  pulse,
    output logic  pending,
    output logic  pending_next
);

    localparam int CNT_W = cnt_width(DEBOUNCE);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic [CNT_W-1:0]       cnt;
    logic                   update;
    logic                   set;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // A level is accepted only once the new value has been seen DEBOUNCE
    // cycles in a row; the mode is looked at on that cycle alone.
    assign update       = (sync_out != level) && (cnt == CNT_W'(DEBOUNCE - 1));
    assign set          = update && edge_match(mode, sync_out);
    assign pending_next = set | (pending & ~clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_out == level) begin
            cnt <= '0;
        end else if (update) begin
            level <= sync_out;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse   <= 1'b0;
            pending <= 1'b0;
        end else begin
            pulse   <= set;
            pending <= pending_next;
        end
    end

endmodule

// File: rtl/edge_detect.sv
// Multi-channel debounced edge detector with sticky event flags and a
// combined interrupt; each channel is an independent edge_detect_chan.
module edge_detect
    import edge_detect_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    edge_detect_if.slave bus
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] pulse;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pending_next;
    logic             irq;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
        SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX ||
        DEBOUNCE < DEBOUNCE_MIN || DEBOUNCE > DEBOUNCE_MAX) begin : g_bad_params
        $error("edge_detect: parameter out of range");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        edge_detect_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .in           (bus.in[i]),
            .mode         (bus.mode),
            .clr          (bus.clr[i]),
            .level        (level[i]),
            .pulse        (pulse[i]),
            .pending      (pending[i]),
            .pending_next (pending_next[i])
        );
    end

    // Reducing the next-state flags lets irq rise on the same edge as pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |pending_next;
        end
    end

    assign bus.level   = level;
    assign bus.pulse   = pulse;
    assign bus.pending = pending;
    assign bus.irq     = irq;

endmodule

// File: tb/tb_edge_detect.sv
// Directed bench for edge_detect with WIDTH=4, SYNC_STAGES=2, DEBOUNCE=3;
// an accepted change appears five edges after the input moves.
module tb_edge_detect;
    import edge_detect_pkg::*;

    localparam int WIDTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    edge_detect_if #(.WIDTH(WIDTH)) bus ();

    edge_detect #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2),
        .DEBOUNCE    (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] in_v, input mode_t mode_v, input logic [3:0] clr_v);
        bus.in   = in_v;
        bus.mode = mode_v;
        bus.clr  = clr_v;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] lvl, input logic [3:0] pls,
                             input logic [3:0] pnd, input logic irq_exp);
        check_output({tag, ".level"},   32'(bus.level),   32'(lvl));
        check_output({tag, ".pulse"},   32'(bus.pulse),   32'(pls));
        check_output({tag, ".pending"}, 32'(bus.pending), 32'(pnd));
        check_output({tag, ".irq"},     32'(bus.irq),     32'(irq_exp));
    endtask

    // Advance n edges expecting no pulse and unchanged flags on every one.
    task automatic quiet(input string tag, input int n, input logic [3:0] pnd, input logic irq_exp);
        for (int k = 0; k < n; k++) begin
            tick(1);
            check_output({tag, ".pulse"},   32'(bus.pulse),   32'(4'b0000));
            check_output({tag, ".pending"}, 32'(bus.pending), 32'(pnd));
            check_output({tag, ".irq"},     32'(bus.irq),     32'(irq_exp));
        end
    endtask

    initial begin
        apply_stimulus(4'b0000, MODE_RISE, 4'b0000);
        rst_n = 1'b0;
        tick(3);
        check_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;
        tick(3);
        check_all("idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);

        $display("[TB] rising edge latency on channel 0");
        apply_stimulus(4'b0001, MODE_RISE, 4'b0000);
        tick(4);
        check_all("t1_pre", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        check_all("t1_edge", 4'b0001, 4'b0001, 4'b0001, 1'b1);
        tick(1);
        check_all("t1_after", 4'b0001, 4'b0000, 4'b0001, 1'b1);
        apply_stimulus(4'b0001, MODE_RISE, 4'b1111);
        tick(1);
        apply_stimulus(4'b0001, MODE_RISE, 4'b0000);
        check_all("t1_clr", 4'b0001, 4'b0000, 4'b0000, 1'b0);

        $display("[TB] two-cycle glitch on channel 1");
        apply_stimulus(4'b0011, MODE_BOTH, 4'b0000);
        tick(2);
        apply_stimulus(4'b0001, MODE_BOTH, 4'b0000);
        quiet("t2_glitch", 8, 4'b0000, 1'b0);
        check_all("t2_end", 4'b0001, 4'b0000, 4'b0000, 1'b0);

        $display("[TB] falling-only mode on channel 2");
        apply_stimulus(4'b0101, MODE_FALL, 4'b0000);
        quiet("t3_rise", 8, 4'b0000, 1'b0);
        check_all("t3_high", 4'b0101, 4'b0000, 4'b0000, 1'b0);
        apply_stimulus(4'b0001, MODE_FALL, 4'b0000);
        tick(4);
        check_all("t3_pre", 4'b0101, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        check_all("t3_fall", 4'b0001, 4'b0100, 4'b0100, 1'b1);
        tick(1);
        check_all("t3_after", 4'b0001, 4'b0000, 4'b0100, 1'b1);
        apply_stimulus(4'b0001, MODE_FALL, 4'b0100);
        tick(1);
        apply_stimulus(4'b0001, MODE_FALL, 4'b0000);
        check_all("t3_clr", 4'b0001, 4'b0000, 4'b0000, 1'b0);

        $display("[TB] set versus clear on channel 3");
        apply_stimulus(4'b1001, MODE_RISE, 4'b0000);
        tick(5);
        check_all("t4_rise", 4'b1001, 4'b1000, 4'b1000, 1'b1);
        tick(1);
        apply_stimulus(4'b0001, MODE_RISE, 4'b0000);
        quiet("t4_fall", 8, 4'b1000, 1'b1);
        check_all("t4_low", 4'b0001, 4'b0000, 4'b1000, 1'b1);
        apply_stimulus(4'b1001, MODE_RISE, 4'b0000);
        tick(4);
        check_all("t4_pre", 4'b0001, 4'b0000, 4'b1000, 1'b1);
        apply_stimulus(4'b1001, MODE_RISE, 4'b1000);
        tick(1);
        apply_stimulus(4'b1001, MODE_RISE, 4'b0000);
        check_all("t4_setwins", 4'b1001, 4'b1000, 4'b1000, 1'b1);
        tick(1);
        check_all("t4_hold", 4'b1001, 4'b0000, 4'b1000, 1'b1);
        apply_stimulus(4'b1001, MODE_RISE, 4'b1000);
        tick(1);
        apply_stimulus(4'b1001, MODE_RISE, 4'b0000);
        check_all("t4_clr", 4'b1001, 4'b0000, 4'b0000, 1'b0);

        $display("[TB] disabled mode on channel 0");
        apply_stimulus(4'b1000, MODE_OFF, 4'b0000);
        quiet("t5_fall", 8, 4'b0000, 1'b0);
        check_all("t5_low", 4'b1000, 4'b0000, 4'b0000, 1'b0);
        apply_stimulus(4'b1001, MODE_OFF, 4'b0000);
        quiet("t5_rise", 8, 4'b0000, 1'b0);
        check_all("t5_high", 4'b1001, 4'b0000, 4'b0000, 1'b0);
        apply_stimulus(4'b1001, MODE_RISE, 4'b0000);
        quiet("t5_switch", 4, 4'b0000, 1'b0);
        check_all("t5_end", 4'b1001, 4'b0000, 4'b0000, 1'b0);

        $display("[TB] simultaneous edges on all channels");
        apply_stimulus(4'b0110, MODE_BOTH, 4'b0000);
        tick(4);
        check_all("t7_pre", 4'b1001, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        check_all("t7_edge", 4'b0110, 4'b1111, 4'b1111, 1'b1);
        apply_stimulus(4'b0110, MODE_BOTH, 4'b1111);
        tick(1);
        apply_stimulus(4'b0110, MODE_BOTH, 4'b0000);
        check_all("t7_clr", 4'b0110, 4'b0000, 4'b0000, 1'b0);

        $display("[TB] reset during debounce on channel 1");
        apply_stimulus(4'b0000, MODE_RISE, 4'b0000);
        quiet("t6_settle", 8, 4'b0000, 1'b0);
        check_all("t6_low", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        apply_stimulus(4'b0010, MODE_RISE, 4'b0000);
        tick(4);
        check_all("t6_partial", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all("t6_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        check_all("t6_pre", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        check_all("t6_edge", 4'b0010, 4'b0010, 4'b0010, 1'b1);
        quiet("t6_single", 6, 4'b0010, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_detect.md
EDGE_DETECT -- requirements
Module: edge_detect

Interface
REQ-001 Parameter WIDTH, default 4, number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flops per channel (2..4).
REQ-003 Parameter DEBOUNCE, default 1, consecutive cycles a changed level must persist before acceptance (1..65535; 1 = no filtering).
REQ-004 clk  input  1  single clock, all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in  input  WIDTH  raw, possibly asynchronous channel inputs.
REQ-007 mode  input  2  edge select: 00 rising, 01 falling, 10 both, 11 disabled; common to all channels.
REQ-008 clr  input  WIDTH  per-channel pending-clear strobe, active high.
REQ-009 level  output  WIDTH  debounced, synchronised channel level.
REQ-010 pulse  output  WIDTH  one-cycle edge pulse per channel, registered.
REQ-011 pending  output  WIDTH  sticky per-channel event flags.
REQ-012 irq  output  1  OR-reduction of pending, registered.

Function
REQ-013 Each channel SHALL pass in[i] through SYNC_STAGES flops; sync_out[i] is the last stage.
REQ-014 Per channel, a debounce counter of width clog2(DEBOUNCE) (min 1) SHALL reset to 0 whenever sync_out equals level.
REQ-015 When sync_out differs from level and counter equals DEBOUNCE-1, level SHALL take sync_out and counter SHALL return to 0; otherwise counter SHALL increment.
REQ-016 A level change at the sync output lasting fewer than DEBOUNCE consecutive cycles SHALL NOT alter level, pulse or pending.
REQ-017 Total latency: a clean input change sampled at edge 1 SHALL update level after edge SYNC_STAGES+DEBOUNCE-1+1 = SYNC_STAGES+DEBOUNCE.
REQ-018 pulse[i] SHALL assert at the same edge level[i] updates, if the transition matches mode (0->1 for 00, 1->0 for 01, either for 10), and SHALL deassert at the next edge.
REQ-019 Mode 11 SHALL suppress pulse and pending setting; level tracking continues.
REQ-020 mode SHALL be sampled at the update edge only; changing mode never produces retroactive pulses.
REQ-021 pending[i] SHALL set at the edge pulse[i] asserts and clear at an edge where clr[i]=1.
REQ-022 Simultaneous set and clr on the same channel: set SHALL win (pending stays 1).
REQ-023 irq SHALL equal the registered OR of next-state pending, i.e. rise in the same cycle as pending.
REQ-024 Channels SHALL be fully independent; simultaneous edges on several channels all pulse in the same cycle.

Reset
REQ-025 While rst_n=0, all sync flops, counters, level, pulse, pending and irq SHALL be 0.
REQ-026 After release, an input held high SHALL be treated as a 0->1 transition and, in mode 00 or 10, produce one pulse after SYNC_STAGES+DEBOUNCE edges.
REQ-027 Reset asserted mid-debounce SHALL discard the partial count with no pulse.

Structure
REQ-028 Package edge_detect_pkg SHALL hold the mode encodings (MODE_RISE, MODE_FALL, MODE_BOTH, MODE_OFF) and parameter limits.
REQ-029 Per-channel logic (synchroniser, debounce counter, level, pulse, pending) SHALL live in sub-module edge_detect_chan, instantiated WIDTH times by generate; irq reduction stays in the top.

Verification (WIDTH=4, SYNC_STAGES=2, DEBOUNCE=3)
REQ-030 Reset release, in=4'b0000, mode=00; in[0] 0->1 held -> level[0] and pulse[0]=1 exactly 5 edges later, pulse 1 cycle wide, pending[0]=1, irq=1.
REQ-031 in[1] high for 2 cycles then low, mode=10 -> no level, pulse or pending change on channel 1.
REQ-032 mode=01, in[2] 1->0 after settled high -> pulse[2] only on the falling transition; rising transition earlier produced none.
REQ-033 pending[3] set; clr[3]=1 on the same edge a new pulse[3] fires -> pending[3] remains 1; clr[3] on a later idle edge -> pending[3]=0, irq=0.
REQ-034 mode=11, toggle in[0] -> level[0] follows, pulse and pending stay 0; switch to 00 with no new edge -> no pulse.
REQ-035 Assert rst_n=0 after 2 of 3 debounce cycles on in[1] -> all outputs 0; after release with in[1] still high -> single pulse 5 edges later.
